// File: rtl/mux_n_1_pipe.sv
// -----------------------------------------------------------------------------
// mux_n_1_pipe
//
// Purpose
//   Parametrised N:1 result selector between the ALU function units and the
//   writeback stage. The selected word (and an out-of-range flag) is captured
//   into a registered output stage. A two-entry buffer (main + skid) gives one
//   beat per clock without any combinational path from out_ready to in_ready.
//
// Parameters
//   WIDTH   data width of each input and of the output
//   NUM_IN  number of inputs, 2..16 (need not be a power of two)
//   SEL_W   select width, 2**SEL_W >= NUM_IN
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_data    in   packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel     in   index of the input to select
//   in_valid   in   in_data/in_sel valid this cycle
//   in_ready   out  block accepts a beat this cycle (registered)
//   out_data   out  selected word (registered)
//   out_err    out  captured in_sel was >= NUM_IN (registered)
//   out_valid  out  out_data/out_err valid
//   out_ready  in   downstream accepts a beat
//   dbg_state  out  current buffer state (0=EMPTY, 1=ONE, 2=TWO)
//
// Handshake: a beat moves across an interface on every rising edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until the transfer; out_valid is never withdrawn without a transfer.
// -----------------------------------------------------------------------------
module mux_n_1_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              dbg_state
);

    if (NUM_IN < 2 || NUM_IN > 16 || (1 << SEL_W) < NUM_IN) begin : g_bad_params
        $error("mux_n_1_pipe: illegal NUM_IN/SEL_W combination");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic               main_err_q, main_err_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic               skid_err_q, skid_err_d;
    logic               in_ready_q;

    logic [WIDTH-1:0]   sel_word;
    logic               sel_err;
    logic               accept;
    logic               drain;

    // Flat AND-OR select: each input is gated by its own one-hot decode term,
    // so no input has priority and an out-of-range select yields all zeros.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            sel_word = sel_word
                     | (in_data[k*WIDTH +: WIDTH] & {WIDTH{in_sel == SEL_W'(k)}});
        end
        // Extra bit keeps the compare correct when NUM_IN == 2**SEL_W.
        sel_err = ({1'b0, in_sel} >= (SEL_W+1)'(NUM_IN));
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_data_d = sel_word;
                    main_err_d  = sel_err;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_data_d = sel_word;
                    main_err_d  = sel_err;
                end else if (accept) begin
                    skid_data_d = sel_word;
                    skid_err_d  = sel_err;
                    state_d     = TWO;
                end else if (drain) begin
                    state_d     = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a drain can move things.
                if (drain) begin
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                    state_d     = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            // Registered ready: low only while the skid entry is occupied.
            in_ready_q  <= (state_d != TWO);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;
    assign out_valid = (state_q != EMPTY);
    assign dbg_state = state_q;

endmodule
